// File: rtl/display_arbiter.sv
// Round-robin arbiter granting one of three requesters the 4-digit display for a fixed hold time.
// Latched values saturate at 9999; an early request drop ends the hold without a done pulse.
module display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 100_000_000,
    parameter int unsigned IDLE_BLANK  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [13:0] num0,
    input  logic [13:0] num1,
    input  logic [13:0] num2,
    output logic [13:0] number,
    output logic        blank,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic        ovf
);

    typedef enum logic [1:0] {StIdle, StHold, StRelease} state_e;

    localparam logic [26:0] HoldLast  = 27'(HOLD_CYCLES - 1);
    localparam logic        IdleBlank = (IDLE_BLANK != 0);
    localparam logic [13:0] MaxShown  = 14'd9999;

    state_e      state_q, state_d;
    logic [26:0] cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic [13:0] number_q, number_d;
    logic        blank_q, blank_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [2:0]  done_q, done_d;
    logic        ovf_q, ovf_d;

    logic [3:0]  req_ext;
    logic [1:0]  win;
    logic [1:0]  cand;
    logic        found;
    logic [13:0] num_sel;

    // Padding bit keeps the round-robin index in range for any 2-bit candidate.
    assign req_ext = {1'b0, req};

    always_comb begin
        win   = 2'd0;
        cand  = 2'd0;
        found = 1'b0;
        for (int unsigned k = 1; k <= 3; k++) begin
            cand = 2'((32'(last_q) + k) % 3);
            if (!found && req_ext[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (win)
            2'd0:    num_sel = num0;
            2'd1:    num_sel = num1;
            default: num_sel = num2;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = 3'b000;
        done_d   = 3'b000;
        number_d = 14'd0;
        blank_d  = IdleBlank;
        ovf_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d  = StHold;
                    cnt_d    = 27'd0;
                    last_d   = win;
                    gnt_d    = 3'b001 << win;
                    blank_d  = 1'b0;
                    if (num_sel > MaxShown) begin
                        number_d = MaxShown;
                        ovf_d    = 1'b1;
                    end else begin
                        number_d = num_sel;
                    end
                end
            end
            StHold: begin
                // last_q is the current owner while holding.
                if (!req_ext[last_q]) begin
                    state_d = StIdle;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRelease;
                    done_d  = 3'b001 << last_q;
                end else begin
                    cnt_d    = cnt_q + 27'd1;
                    gnt_d    = gnt_q;
                    number_d = number_q;
                    ovf_d    = ovf_q;
                    blank_d  = 1'b0;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 27'd0;
            last_q   <= 2'd2;
            gnt_q    <= 3'b000;
            done_q   <= 3'b000;
            number_q <= 14'd0;
            blank_q  <= IdleBlank;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            number_q <= number_d;
            blank_q  <= blank_d;
            ovf_q    <= ovf_d;
        end
    end

    assign number = number_q;
    assign blank  = blank_q;
    assign gnt    = gnt_q;
    assign done   = done_q;
    assign ovf    = ovf_q;

endmodule
